// File: rtl/rom_load_ctrl.sv
// rom_load_ctrl: steers HPS download bytes into the cpu/snd/gfx ROM regions and
// sequences the game-core reset around a download (IDLE -> LOAD -> HOLD -> RUN).
// Optional feature macro: ROM_CHECKSUM_EN adds the rom_sum additive checksum port.
module rom_load_ctrl #(
    parameter int HOLD_CYCLES = 1024
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        dn_download,
    input  logic        dn_wr,
    input  logic [15:0] dn_addr,
    input  logic [7:0]  dn_data,
    input  logic        user_reset,
    output logic [13:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic        cpu_rom_we,
    output logic        snd_rom_we,
    output logic        gfx_rom_we,
    output logic        game_reset,
    output logic        load_done,
    output logic        load_err
`ifdef ROM_CHECKSUM_EN
    ,
    output logic [7:0]  rom_sum
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

    state_t      state, state_nxt;
    logic [15:0] hold_cnt, hold_cnt_nxt;
    logic        wr_acc;
    logic        in_cpu, in_snd, in_gfx, in_map;
    logic        load_entry;

    // A byte counts only while the download window is open.
    assign wr_acc = dn_wr & dn_download;

    assign in_cpu = (dn_addr < 16'h4000);
    assign in_snd = (dn_addr >= 16'h4000) && (dn_addr < 16'h5800);
    assign in_gfx = (dn_addr >= 16'h5800) && (dn_addr < 16'h6800);
    assign in_map = (dn_addr < 16'h6800);

    // Any transition into LOAD starts a fresh download (clears error/sum).
    assign load_entry = (state != LOAD) && (state_nxt == LOAD);

    // State and hold-counter registers.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            hold_cnt <= 16'd0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    // Next-state, hold countdown and reset/done outputs.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        game_reset   = 1'b1;
        load_done    = 1'b0;
        case (state)
            IDLE: begin
                if (dn_download) state_nxt = LOAD;
            end
            LOAD: begin
                if (!dn_download) begin
                    state_nxt    = HOLD;
                    hold_cnt_nxt = 16'(HOLD_CYCLES - 1);
                end
            end
            HOLD: begin
                if (dn_download)          state_nxt    = LOAD;
                else if (hold_cnt == '0)  state_nxt    = RUN;
                else                      hold_cnt_nxt = hold_cnt - 16'd1;
            end
            RUN: begin
                game_reset = user_reset;
                load_done  = 1'b1;
                if (dn_download) state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered write port: one region strobe per accepted in-map byte, address
    // and data held between writes. Region offsets reduce to 14-bit arithmetic
    // because 0x4000 has zero low bits and 0x5800 mod 0x4000 is 0x1800.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cpu_rom_we <= 1'b0;
            snd_rom_we <= 1'b0;
            gfx_rom_we <= 1'b0;
            rom_addr   <= 14'd0;
            rom_data   <= 8'd0;
        end else begin
            cpu_rom_we <= wr_acc & in_cpu;
            snd_rom_we <= wr_acc & in_snd;
            gfx_rom_we <= wr_acc & in_gfx;
            if (wr_acc && in_map) begin
                rom_addr <= in_gfx ? (dn_addr[13:0] - 14'h1800) : dn_addr[13:0];
                rom_data <= dn_data;
            end
        end
    end

    // Sticky out-of-map flag; a write in the entry cycle belongs to the new download.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)                  load_err <= 1'b0;
        else if (wr_acc && !in_map)    load_err <= 1'b1;
        else if (load_entry)           load_err <= 1'b0;
    end

`ifdef ROM_CHECKSUM_EN
    // Additive checksum of accepted in-map bytes, restarted on LOAD entry.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)                rom_sum <= 8'd0;
        else if (load_entry)         rom_sum <= (wr_acc && in_map) ? dn_data : 8'd0;
        else if (wr_acc && in_map)   rom_sum <= rom_sum + dn_data;
    end
`endif

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Testbench for rom_load_ctrl: directed download scenarios, expected ROM writes
// queued by the stimulus and checked by an independent monitor.
// Honours ROM_CHECKSUM_EN when defined for the build.
module tb_rom_load_ctrl;

    localparam int HC = 16;
    localparam int R_CPU = 0, R_SND = 1, R_GFX = 2, R_NONE = 3;

    typedef struct {
        int          region;
        logic [13:0] addr;
        logic [7:0]  data;
        int          cyc;
    } exp_wr_t;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        dn_download = 1'b0;
    logic        dn_wr = 1'b0;
    logic [15:0] dn_addr = '0;
    logic [7:0]  dn_data = '0;
    logic        user_reset = 1'b0;
    logic [13:0] rom_addr;
    logic [7:0]  rom_data;
    logic        cpu_rom_we, snd_rom_we, gfx_rom_we;
    logic        game_reset, load_done, load_err;
`ifdef ROM_CHECKSUM_EN
    logic [7:0]  rom_sum;
`endif

    int      errors = 0;
    int      checks = 0;
    int      cyc = 0;
    logic [7:0] sum_model = 8'd0;
    exp_wr_t exp_q[$];

    rom_load_ctrl #(.HOLD_CYCLES(HC)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .dn_download(dn_download), .dn_wr(dn_wr),
        .dn_addr(dn_addr), .dn_data(dn_data), .user_reset(user_reset),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .cpu_rom_we(cpu_rom_we), .snd_rom_we(snd_rom_we), .gfx_rom_we(gfx_rom_we),
        .game_reset(game_reset), .load_done(load_done), .load_err(load_err)
`ifdef ROM_CHECKSUM_EN
        , .rom_sum(rom_sum)
`endif
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Issue one byte write; the expected strobe is queued for the next cycle.
    task automatic write_byte(input logic [15:0] a, input logic [7:0] d,
                              input int region, input logic [13:0] exp_a);
        exp_wr_t e;
        dn_wr   = 1'b1;
        dn_addr = a;
        dn_data = d;
        if (dn_download && region != R_NONE) begin
            e.region = region;
            e.addr   = exp_a;
            e.data   = d;
            e.cyc    = cyc + 1;
            exp_q.push_back(e);
            sum_model = sum_model + d;
        end
        tick();
        dn_wr = 1'b0;
    endtask

    // Monitor: every strobe must match the head of the expected queue.
    always @(negedge clk_sys) begin
        logic [2:0] we_vec;
        exp_wr_t    e;
        we_vec = {gfx_rom_we, snd_rom_we, cpu_rom_we};
        if (reset_n && we_vec != 3'b000) begin
            if (exp_q.size() == 0) begin
                check("unexpected_we", 32'(we_vec), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("we_region", 32'(we_vec), 32'(3'b001 << e.region));
                check("we_addr", 32'(rom_addr), 32'(e.addr));
                check("we_data", 32'(rom_data), 32'(e.data));
                check("we_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Count cycles until load_done, confirming game_reset stays high meanwhile.
    task automatic measure_hold(input string name);
        int n = 0;
        int early = 0;
        while (!load_done && n < 40) begin
            if (!game_reset) early++;
            tick();
            n++;
        end
        check({name, "_len"}, 32'(n), 32'(HC + 1));
        check({name, "_early_release"}, 32'(early), 32'd0);
        check({name, "_run_game_reset"}, 32'(game_reset), 32'd0);
    endtask

    initial begin
        int bad;
        // Reset values while reset_n is low.
        #12;
        check("rst_game_reset", 32'(game_reset), 32'd1);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_load_err", 32'(load_err), 32'd0);
        check("rst_we", 32'({cpu_rom_we, snd_rom_we, gfx_rom_we}), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_rom_data", 32'(rom_data), 32'd0);
        tick();
        reset_n = 1'b1;

        // Long idle: core held in reset, never done.
        bad = 0;
        repeat (5000) begin
            tick();
            if (game_reset !== 1'b1 || load_done !== 1'b0) bad++;
        end
        check("idle_5000_bad_cycles", 32'(bad), 32'd0);

        // Stray write outside download window is ignored.
        write_byte(16'h0005, 8'h77, R_NONE, 14'd0);
        tick();

        // Download: the three reference bytes back to back.
        dn_download = 1'b1;
        sum_model   = 8'd0;
        tick();
        check("load_game_reset", 32'(game_reset), 32'd1);
        check("load_load_done", 32'(load_done), 32'd0);
        write_byte(16'h0000, 8'hA5, R_CPU, 14'h0000);
        write_byte(16'h4001, 8'h3C, R_SND, 14'h0001);
        write_byte(16'h5802, 8'h11, R_GFX, 14'h0002);
        tick();
`ifdef ROM_CHECKSUM_EN
        check("sum_ref", 32'(rom_sum), 32'h0000_00F2);
`endif
        // Region boundaries, then out-of-map drops.
        write_byte(16'h3FFF, 8'h01, R_CPU, 14'h3FFF);
        write_byte(16'h4000, 8'h02, R_SND, 14'h0000);
        write_byte(16'h57FF, 8'h03, R_SND, 14'h17FF);
        write_byte(16'h5800, 8'h04, R_GFX, 14'h0000);
        write_byte(16'h67FF, 8'h05, R_GFX, 14'h0FFF);
        tick();
        check("err_before_drop", 32'(load_err), 32'd0);
        write_byte(16'h6800, 8'h80, R_NONE, 14'd0);
        write_byte(16'hFFFF, 8'h40, R_NONE, 14'd0);
        tick();
        check("err_after_drop", 32'(load_err), 32'd1);
        check("hold_rom_addr", 32'(rom_addr), 32'h0FFF);
        check("hold_rom_data", 32'(rom_data), 32'h05);
`ifdef ROM_CHECKSUM_EN
        check("sum_after_drop", 32'(rom_sum), 32'h0000_0001);
`endif
        // Last byte just before the window closes; write on the falling cycle is ignored.
        write_byte(16'h0100, 8'h5A, R_CPU, 14'h0100);
        dn_download = 1'b0;
        dn_wr       = 1'b1;
        dn_addr     = 16'h0010;
        dn_data     = 8'hEE;
        tick();
        dn_wr = 1'b0;
        // One cycle of HOLD already elapsed; the helper adds the rest.
        begin
            int n = 1;
            int early = 0;
            while (!load_done && n < 40) begin
                if (!game_reset) early++;
                tick();
                n++;
            end
            check("hold1_len", 32'(n), 32'(HC + 1));
            check("hold1_early_release", 32'(early), 32'd0);
            check("hold1_run_game_reset", 32'(game_reset), 32'd0);
        end
        check("run_err_sticky", 32'(load_err), 32'd1);

        // user_reset passes straight through in RUN.
        user_reset = 1'b1;
        #1;
        check("user_reset_hi", 32'(game_reset), 32'd1);
        user_reset = 1'b0;
        #1;
        check("user_reset_lo", 32'(game_reset), 32'd0);
        tick();

        // Re-download from RUN.
        dn_download = 1'b1;
        sum_model   = 8'd0;
        #1;
        check("reload_same_cycle", 32'(game_reset), 32'd0);
        tick();
        check("reload_game_reset", 32'(game_reset), 32'd1);
        check("reload_load_done", 32'(load_done), 32'd0);
        check("reload_err_cleared", 32'(load_err), 32'd0);
`ifdef ROM_CHECKSUM_EN
        check("reload_sum_cleared", 32'(rom_sum), 32'd0);
`endif
        // Abort HOLD when the counter reads 5.
        dn_download = 1'b0;
        repeat (11) tick();
        dn_download = 1'b1;
        tick();
        check("abort_game_reset", 32'(game_reset), 32'd1);
        check("abort_load_done", 32'(load_done), 32'd0);
        bad = 0;
        repeat (20) begin
            tick();
            if (load_done !== 1'b0 || game_reset !== 1'b1) bad++;
        end
        check("abort_stays_load", 32'(bad), 32'd0);
        dn_download = 1'b0;
        measure_hold("hold2");

        // Reset mid-LOAD after 100 bytes.
        dn_download = 1'b1;
        sum_model   = 8'd0;
        tick();
        for (int i = 0; i < 100; i++) write_byte(16'(i), 8'(i), R_CPU, 14'(i));
        write_byte(16'h7000, 8'h01, R_NONE, 14'd0);
        tick();
        check("pre_reset_drained", 32'(exp_q.size()), 32'd0);
        reset_n = 1'b0;
        #1;
        check("mid_rst_game_reset", 32'(game_reset), 32'd1);
        check("mid_rst_load_done", 32'(load_done), 32'd0);
        check("mid_rst_load_err", 32'(load_err), 32'd0);
        check("mid_rst_rom_addr", 32'(rom_addr), 32'd0);
        check("mid_rst_rom_data", 32'(rom_data), 32'd0);
        check("mid_rst_we", 32'({cpu_rom_we, snd_rom_we, gfx_rom_we}), 32'd0);
`ifdef ROM_CHECKSUM_EN
        check("mid_rst_sum", 32'(rom_sum), 32'd0);
`endif
        write_byte(16'h0003, 8'h33, R_NONE, 14'd0);
        dn_download = 1'b0;
        tick();
        reset_n = 1'b1;
        // Writes without a download must not strobe (monitor flags any).
        for (int i = 0; i < 10; i++) write_byte(16'(i), 8'hC0, R_NONE, 14'd0);
        tick();
        check("post_rst_game_reset", 32'(game_reset), 32'd1);
        check("post_rst_load_done", 32'(load_done), 32'd0);

        // New download works after the aborted one.
        dn_download = 1'b1;
        sum_model   = 8'd0;
        tick();
        write_byte(16'h0123, 8'h5A, R_CPU, 14'h0123);
        tick();
        check("new_load_err", 32'(load_err), 32'd0);
`ifdef ROM_CHECKSUM_EN
        check("new_sum", 32'(rom_sum), 32'(sum_model));
`endif
        dn_download = 1'b0;
        repeat (3) tick();
        check("final_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
